// File: rtl/jk_seq_driver.sv
// rtl/jk_seq_driver.sv - excitation driver for an external falling-edge JK flip-flop bank
//
// Purpose: on every rising edge in RUN (or on a load) this block samples the bank
// outputs, picks the next target value (hold / binary up / binary down / Gray up,
// or Load_Value) and registers per-bit J/K excitation that moves the bank there on
// the following falling edge. The next rising edge verifies the bank actually
// arrived; a miss latches Mismatch and parks the driver in FAULT until Clear_Fault.
//
// Ports:
//   Clk          in   rising-edge clock for this driver
//   Reset        in   asynchronous, active-high reset
//   Start        in   IDLE -> RUN request (ignored with Stop or Load)
//   Stop         in   RUN -> IDLE request
//   Mode[1:0]    in   00 hold, 01 binary up, 10 binary down, 11 Gray up
//   Load         in   force target to Load_Value this cycle
//   Load_Value   in   load target
//   Clear_Fault  in   leave FAULT and clear Mismatch
//   Q_fb         in   Q outputs of the external JK bank
//   J, K         out  registered excitation, one bit per flip-flop
//   Busy         out  high in RUN or for the cycle after a load
//   Tc           out  terminal count of the registered target
//   Mismatch     out  sticky "bank missed its target" flag

module jk_seq_driver #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic [1:0]       Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Value,
  input  logic             Clear_Fault,
  input  logic [WIDTH-1:0] Q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             Busy,
  output logic             Tc,
  output logic             Mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = '0;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  localparam logic [WIDTH-1:0] GRAY_LAST = ALL_ONES ^ (ALL_ONES >> 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             check_valid_q, check_valid_d;

  logic [WIDTH-1:0] rule_target;
  logic [WIDTH-1:0] target;
  logic             tc_hit;
  logic             miss;
  logic             arm;

  // Target selection; unsigned arithmetic wraps naturally at both ends.
  always_comb begin
    rule_target = Q_fb;
    case (Mode)
      2'b01:   rule_target = Q_fb + 1'b1;
      2'b10:   rule_target = Q_fb - 1'b1;
      2'b11:   rule_target = bin2gray(gray2bin(Q_fb) + 1'b1);
      default: rule_target = Q_fb;
    endcase
    target = Load ? Load_Value : rule_target;
    tc_hit = ((Mode == 2'b01) && (target == ALL_ONES)) ||
             ((Mode == 2'b10) && (target == ZERO)) ||
             ((Mode == 2'b11) && (target == GRAY_LAST));
    miss   = check_valid_q && (Q_fb != expected_q);
  end

  always_comb begin
    state_d       = state_q;
    j_d           = '0;
    k_d           = '0;
    busy_d        = 1'b0;
    tc_d          = 1'b0;
    mismatch_d    = mismatch_q;
    expected_d    = expected_q;
    check_valid_d = 1'b0;
    arm           = 1'b0;

    // A failed check outranks every request seen on the same edge.
    if (miss) begin
      state_d    = ST_FAULT;
      mismatch_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Load) begin
            arm = 1'b1;
          end else if (Start && !Stop) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (Stop) begin
            state_d = ST_IDLE;
          end
          arm = Load || !Stop;
        end
        ST_FAULT: begin
          if (Clear_Fault) begin
            state_d    = ST_IDLE;
            mismatch_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Set/reset-only excitation: toggle (J=K=1) is never produced.
    if (arm) begin
      j_d           = ~Q_fb & target;
      k_d           = Q_fb & ~target;
      expected_d    = target;
      check_valid_d = 1'b1;
      tc_d          = tc_hit;
    end
    busy_d = arm || (state_d == ST_RUN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      j_q           <= '0;
      k_q           <= '0;
      busy_q        <= 1'b0;
      tc_q          <= 1'b0;
      mismatch_q    <= 1'b0;
      expected_q    <= '0;
      check_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      j_q           <= j_d;
      k_q           <= k_d;
      busy_q        <= busy_d;
      tc_q          <= tc_d;
      mismatch_q    <= mismatch_d;
      expected_q    <= expected_d;
      check_valid_q <= check_valid_d;
    end
  end

  assign J        = j_q;
  assign K        = k_q;
  assign Busy     = busy_q;
  assign Tc       = tc_q;
  assign Mismatch = mismatch_q;

endmodule
